// File: rtl/intr_ctrl_pkg.sv
// Shared widths, FSM state type and limits for the interrupt controller.
package intr_ctrl_pkg;
  localparam int unsigned DATA_W         = 16;
  localparam int unsigned PC_BR_SEL_W    = 1;
  localparam int unsigned PC_IMR_SEL_W   = 1;
  localparam int unsigned INTR_ST_W      = 2;
  localparam int unsigned INTR_N_IRQ_MAX = 8;
  localparam int unsigned INTR_IDX_W     = $clog2(INTR_N_IRQ_MAX);

  typedef enum logic [INTR_ST_W-1:0] {
    INTR_ST_IDLE    = 2'd0,
    INTR_ST_TAKE    = 2'd1,
    INTR_ST_SERVICE = 2'd2
  } intr_st_e;
endpackage

// File: rtl/intr_ctrl_prio_enc.sv
// Fixed-priority encoder: lowest set request index wins.
module intr_prio_enc
  import intr_ctrl_pkg::*;
#(
  parameter int unsigned N_IRQ = 4
) (
  input  logic [N_IRQ-1:0]      req_i,
  output logic                  valid_o,
  output logic [INTR_IDX_W-1:0] idx_o
);
  always_comb begin
    valid_o = 1'b0;
    idx_o   = '0;
    for (int unsigned i = 0; i < N_IRQ; i++) begin
      if (req_i[i] && !valid_o) begin
        valid_o = 1'b1;
        idx_o   = INTR_IDX_W'(i);
      end
    end
  end
endmodule

// File: rtl/intr_ctrl.sv
// Interrupt controller steering the PC branch controls to vectors and back.
// Optional per-line mask register enabled by defining INTR_MASK_EN.
module intr_ctrl
  import intr_ctrl_pkg::*;
#(
  parameter int unsigned       N_IRQ     = 4,
  parameter logic [DATA_W-1:0] VEC_BASE  = 16'h0010,
  parameter int unsigned       VEC_SHIFT = 1
) (
  input  logic                    clock_i,
  input  logic                    rst_i,
  input  logic [N_IRQ-1:0]        irq_i,
  input  logic [DATA_W-1:0]       pc_i,
  input  logic                    insn_done_i,
  input  logic                    reti_i,
  input  logic                    ie_set_i,
  input  logic                    ie_clr_i,
  input  logic [PC_BR_SEL_W-1:0]  core_br_sel_i,
  input  logic [PC_IMR_SEL_W-1:0] core_imr_sel_i,
  input  logic [DATA_W-1:0]       core_rs_i,
`ifdef INTR_MASK_EN
  input  logic                    mask_we_i,
  input  logic [N_IRQ-1:0]        mask_wdata_i,
`endif
  output logic [PC_BR_SEL_W-1:0]  br_sel_o,
  output logic [PC_IMR_SEL_W-1:0] imr_sel_o,
  output logic [DATA_W-1:0]       rs_o,
  output logic                    flush_o,
  output logic [N_IRQ-1:0]        irq_ack_o,
  output logic                    in_service_o,
  output logic [DATA_W-1:0]       epc_o
);
  intr_st_e              state_q, state_d;
  logic [N_IRQ-1:0]      irq_q, pend_q, pend_d, rise, take_oh, req, mask;
  logic [INTR_IDX_W-1:0] idx_q, idx_d, enc_idx;
  logic                  enc_valid, ie_q, ie_d, ret;
  logic [DATA_W-1:0]     epc_q, vec;

`ifdef INTR_MASK_EN
  logic [N_IRQ-1:0] mask_q;
  always_ff @(posedge clock_i or posedge rst_i) begin
    if (rst_i)          mask_q <= '1;
    else if (mask_we_i) mask_q <= mask_wdata_i;
  end
  assign mask = mask_q;
`else
  assign mask = '1;
`endif

  assign rise    = irq_i & ~irq_q;
  assign req     = pend_q & mask;
  assign take_oh = (state_q == INTR_ST_TAKE) ? (N_IRQ'(1) << idx_q) : '0;
  assign vec     = VEC_BASE + (DATA_W'(idx_q) << VEC_SHIFT);

  intr_prio_enc #(.N_IRQ(N_IRQ)) u_prio (
    .req_i   (req),
    .valid_o (enc_valid),
    .idx_o   (enc_idx)
  );

  // New edges are ORed in after the TAKE clear so a same-cycle edge survives.
  assign pend_d = (pend_q & ~take_oh) | rise;

  always_comb begin
    ie_d = ie_q;
    if (ie_set_i)                ie_d = 1'b1;
    if (ie_clr_i)                ie_d = 1'b0;
    if (state_q == INTR_ST_TAKE) ie_d = 1'b0;
    if (ret)                     ie_d = 1'b1;
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    ret          = 1'b0;
    br_sel_o     = core_br_sel_i;
    imr_sel_o    = core_imr_sel_i;
    rs_o         = core_rs_i;
    flush_o      = 1'b0;
    irq_ack_o    = take_oh;
    in_service_o = (state_q != INTR_ST_IDLE);
    case (state_q)
      INTR_ST_IDLE: begin
        if (insn_done_i && ie_q && enc_valid) begin
          state_d = INTR_ST_TAKE;
          idx_d   = enc_idx;
        end
      end
      INTR_ST_TAKE: begin
        br_sel_o  = PC_BR_SEL_W'(1);
        imr_sel_o = PC_IMR_SEL_W'(1);
        rs_o      = vec;
        flush_o   = 1'b1;
        state_d   = INTR_ST_SERVICE;
      end
      INTR_ST_SERVICE: begin
        if (insn_done_i && reti_i) begin
          ret       = 1'b1;
          br_sel_o  = PC_BR_SEL_W'(1);
          imr_sel_o = PC_IMR_SEL_W'(1);
          rs_o      = epc_q;
          state_d   = INTR_ST_IDLE;
        end
      end
      default: state_d = INTR_ST_IDLE;
    endcase
  end

  always_ff @(posedge clock_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= INTR_ST_IDLE;
      irq_q   <= '0;
      pend_q  <= '0;
      idx_q   <= '0;
      ie_q    <= 1'b0;
      epc_q   <= '0;
    end else begin
      state_q <= state_d;
      irq_q   <= irq_i;
      pend_q  <= pend_d;
      idx_q   <= idx_d;
      ie_q    <= ie_d;
      if (state_q == INTR_ST_TAKE) epc_q <= pc_i;
    end
  end

  assign epc_o = epc_q;
endmodule

// File: tb/tb_intr_ctrl.sv
// Self-checking bench for intr_ctrl: directed scenarios then random traffic vs a behavioural model.
module tb_intr_ctrl;
  import intr_ctrl_pkg::*;

  localparam int unsigned N = 4;

  logic              clk = 1'b0;
  logic              rst_i;
  logic [N-1:0]      irq_i;
  logic [15:0]       pc_i, core_rs_i;
  logic              insn_done_i, reti_i, ie_set_i, ie_clr_i;
  logic [0:0]        core_br_sel_i, core_imr_sel_i;
  logic              mask_we_i;
  logic [N-1:0]      mask_wdata_i;
  logic [0:0]        br_sel_o, imr_sel_o;
  logic [15:0]       rs_o, epc_o;
  logic              flush_o, in_service_o;
  logic [N-1:0]      irq_ack_o;

  int vectors = 0;
  int miscompares = 0;

  // Model state: phase flags rather than an encoded state.
  bit          m_taking, m_serving, m_ie;
  bit [N-1:0]  m_pend, m_prev, m_mask;
  int          m_idx;
  bit [15:0]   m_epc;

  always #5 clk = ~clk;

  intr_ctrl #(.N_IRQ(N), .VEC_BASE(16'h0010), .VEC_SHIFT(1)) dut (
    .clock_i        (clk),
    .rst_i          (rst_i),
    .irq_i          (irq_i),
    .pc_i           (pc_i),
    .insn_done_i    (insn_done_i),
    .reti_i         (reti_i),
    .ie_set_i       (ie_set_i),
    .ie_clr_i       (ie_clr_i),
    .core_br_sel_i  (core_br_sel_i),
    .core_imr_sel_i (core_imr_sel_i),
    .core_rs_i      (core_rs_i),
`ifdef INTR_MASK_EN
    .mask_we_i      (mask_we_i),
    .mask_wdata_i   (mask_wdata_i),
`endif
    .br_sel_o       (br_sel_o),
    .imr_sel_o      (imr_sel_o),
    .rs_o           (rs_o),
    .flush_o        (flush_o),
    .irq_ack_o      (irq_ack_o),
    .in_service_o   (in_service_o),
    .epc_o          (epc_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_taking = 0; m_serving = 0; m_ie = 0;
    m_pend = '0; m_prev = '0; m_mask = '1; m_idx = 0; m_epc = '0;
  endtask

  task automatic check_outputs();
    bit ret;
    bit [15:0] exp_rs;
    ret = m_serving && insn_done_i && reti_i;
    exp_rs = m_taking ? 16'(16'h0010 + m_idx * 2) : (ret ? m_epc : core_rs_i);
    chk("br_sel",  32'(br_sel_o),  32'((m_taking || ret) ? 1'b1 : core_br_sel_i));
    chk("imr_sel", 32'(imr_sel_o), 32'((m_taking || ret) ? 1'b1 : core_imr_sel_i));
    chk("rs",      32'(rs_o),      32'(exp_rs));
    chk("flush",   32'(flush_o),   32'(m_taking));
    chk("irq_ack", 32'(irq_ack_o), m_taking ? (32'd1 << m_idx) : 32'd0);
    chk("in_svc",  32'(in_service_o), 32'(m_taking || m_serving));
    chk("epc",     32'(epc_o),     32'(m_epc));
  endtask

  task automatic model_step();
    bit [N-1:0] rise, req;
    bit ret, new_ie;
    rise = irq_i & ~m_prev;
    req  = m_pend & m_mask;
    ret  = m_serving && insn_done_i && reti_i;
    new_ie = m_ie;
    if (ie_set_i) new_ie = 1;
    if (ie_clr_i) new_ie = 0;
    if (m_taking) new_ie = 0;
    if (ret)      new_ie = 1;
    if (m_taking) begin
      m_pend[m_idx] = 1'b0;
      m_taking  = 0;
      m_serving = 1;
      m_epc     = pc_i;
    end else if (ret) begin
      m_serving = 0;
    end else if (!m_serving && insn_done_i && m_ie && req != 0) begin
      m_taking = 1;
      m_idx = 0;
      while (req[m_idx] == 1'b0) m_idx++;
    end
    m_pend = m_pend | rise;
    m_ie   = new_ie;
    m_prev = irq_i;
`ifdef INTR_MASK_EN
    if (mask_we_i) m_mask = mask_wdata_i;
`endif
  endtask

  // Called at a falling edge with inputs already driven; returns at the next falling edge.
  task automatic cycle();
    #1 check_outputs();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    #1 model_reset();
    check_outputs();
    @(negedge clk);
    check_outputs();
    rst_i = 1'b0;
  endtask

  task automatic quiet();
    insn_done_i = 0; reti_i = 0; ie_set_i = 0; ie_clr_i = 0; mask_we_i = 0;
  endtask

  initial begin
    rst_i = 1'b1; irq_i = '0; pc_i = '0; core_rs_i = 16'h1234;
    core_br_sel_i = '0; core_imr_sel_i = '0; mask_wdata_i = '1;
    quiet();
    @(negedge clk);
    do_reset();

    // Single edge on line 2, taken at an instruction boundary.
    ie_set_i = 1; cycle(); ie_set_i = 0;
    irq_i = 4'b0100; cycle();
    insn_done_i = 1; pc_i = 16'h0040; cycle();
    insn_done_i = 0;
    #1 chk("t1_rs", 32'(rs_o), 32'h0014);
    chk("t1_ack", 32'(irq_ack_o), 32'b0100);
    chk("t1_flush", 32'(flush_o), 32'd1);
    cycle();
    chk("t1_epc", 32'(epc_o), 32'h0040);
    cycle();

    // Return from interrupt.
    insn_done_i = 1; reti_i = 1; pc_i = 16'h0016;
    #1 chk("ret_rs", 32'(rs_o), 32'h0040);
    chk("ret_br", 32'(br_sel_o), 32'd1);
    cycle(); quiet();

    // Simultaneous edges on lines 1 and 3: line 1 first, line 3 after reti.
    irq_i = 4'b1010; cycle();
    insn_done_i = 1; pc_i = 16'h0080; cycle(); quiet();
    #1 chk("t2_rs", 32'(rs_o), 32'h0012);
    chk("t2_ack", 32'(irq_ack_o), 32'b0010);
    cycle();
    insn_done_i = 1; reti_i = 1; cycle(); reti_i = 0;
    chk("t2_idle", 32'(in_service_o), 32'd0);
    cycle(); quiet();
    #1 chk("t2_rs3", 32'(rs_o), 32'h0016);
    cycle();
    insn_done_i = 1; reti_i = 1; cycle(); quiet();

    // Set and clear together: clear wins, so a new edge stays pending.
    ie_set_i = 1; ie_clr_i = 1; irq_i = 4'b0000; cycle(); quiet();
    irq_i = 4'b0001; cycle();
    insn_done_i = 1; cycle(); cycle();
    chk("t4_blocked", 32'(in_service_o), 32'd0);
    insn_done_i = 0; ie_set_i = 1; cycle(); quiet();
    insn_done_i = 1; cycle(); quiet();
    #1 chk("t4_rs", 32'(rs_o), 32'h0010);
    cycle();

    // Reset while in service.
    core_rs_i = 16'hBEEF; core_br_sel_i = 1'b0; core_imr_sel_i = 1'b1;
    do_reset();
    chk("rst_epc", 32'(epc_o), 32'd0);
    chk("rst_rs", 32'(rs_o), 32'hBEEF);

`ifdef INTR_MASK_EN
    ie_set_i = 1; mask_we_i = 1; mask_wdata_i = 4'b1110; irq_i = 4'b0000; cycle(); quiet();
    irq_i = 4'b0001; cycle();
    insn_done_i = 1; cycle(); cycle();
    chk("mask_blk", 32'(in_service_o), 32'd0);
    insn_done_i = 0; mask_we_i = 1; mask_wdata_i = 4'b1111; cycle(); quiet();
    insn_done_i = 1; cycle(); quiet();
    #1 chk("mask_rs", 32'(rs_o), 32'h0010);
    cycle();
    insn_done_i = 1; reti_i = 1; cycle(); quiet();
`endif

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) irq_i[$urandom_range(0, N-1)] ^= 1'b1;
      insn_done_i    = ($urandom_range(0, 9) < 7);
      reti_i         = ($urandom_range(0, 3) == 0);
      ie_set_i       = ($urandom_range(0, 9) == 0);
      ie_clr_i       = ($urandom_range(0, 19) == 0);
      pc_i           = 16'($urandom);
      core_rs_i      = 16'($urandom);
      core_br_sel_i  = 1'($urandom);
      core_imr_sel_i = 1'($urandom);
      mask_we_i      = ($urandom_range(0, 15) == 0);
      mask_wdata_i   = N'($urandom);
      if ($urandom_range(0, 299) == 0) do_reset();
      else cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/intr_ctrl.md
# intr_ctrl

Interrupt controller that sequences the program counter. It latches rising edges on up to N_IRQ request lines and picks the highest-priority enabled request. At an instruction boundary it overrides the core's branch controls so the PC jumps absolutely to a per-line vector, and it saves the return address. On a return-from-interrupt it redirects the PC back to that address. It sits between the core's branch decode and the PC's `br_sel`/`imr_sel`/`rs` inputs.

## Interface
- N_IRQ, 4: number of request lines (1..8).
- VEC_BASE, 16'h0010: address of vector 0.
- VEC_SHIFT, 1: vector stride is 2^VEC_SHIFT words.
- clock  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- irq  in  N_IRQ  request lines, synchronous to clock; a rising edge (0→1) latches a pending bit.
- pc  in  DATA_W  current PC register value.
- insn_done  in  1  current instruction completes this cycle (safe point).
- reti  in  1  return-from-interrupt instruction; only meaningful with insn_done.
- ie_set, ie_clr  in  1 each  set/clear global interrupt enable.
- core_br_sel  in  PC_BR_SEL_W  core branch-enable request.
- core_imr_sel  in  PC_IMR_SEL_W  core absolute/relative select.
- core_rs  in  DATA_W  core absolute target.
- mask_we  in  1  mask write strobe (INTR_MASK_EN only).
- mask_wdata  in  N_IRQ  new mask value (INTR_MASK_EN only).
- br_sel  out  PC_BR_SEL_W  to PC.
- imr_sel  out  PC_IMR_SEL_W  to PC.
- rs  out  DATA_W  to PC.
- flush  out  1  core squashes the instruction at `pc` this cycle.
- irq_ack  out  N_IRQ  one-hot pulse in the cycle the vector is taken.
- in_service  out  1  handler active.
- epc  out  DATA_W  saved return address.

## Operation
- States: IDLE, TAKE, SERVICE.
- Pending: `pend[i]` is set on a rising edge of `irq[i]`. It is cleared in the TAKE cycle for the taken index. If set and clear hit the same bit in the same cycle, set wins.
- Request: `req = pend & mask`. Index 0 has the highest priority.
- Global enable `ie`:
  - `ie_clr` clears it and `ie_set` sets it; if both are asserted, clear wins.
  - TAKE clears `ie`; an accepted reti sets it.
- IDLE → TAKE when `insn_done & ie & |req`. The winning index is latched at this point.
- TAKE, exactly one cycle:
  - `br_sel=1`, `imr_sel=1`, `rs = VEC_BASE + (idx << VEC_SHIFT)`, computed modulo 2^DATA_W.
  - `epc <= pc`, `flush=1`, `irq_ack[idx]=1`.
  - Clear `pend[idx]`.
  - `insn_done` is ignored in this cycle.
  - Next state: SERVICE.
- SERVICE → IDLE on `insn_done & reti`. In that same cycle: `br_sel=1`, `imr_sel=1`, `rs=epc`, `ie<=1`. No flush.
- Otherwise, in IDLE and SERVICE, `br_sel`/`imr_sel`/`rs` pass through from the `core_*` inputs combinationally.
- reti in IDLE passes through unmodified; no redirect.
- In SERVICE, new edges still latch into `pend` but cannot be taken (no nesting, `ie=0` unless software sets it).
  - If software sets `ie` in SERVICE, requests are still not taken until IDLE.
- `in_service` = 1 in TAKE and SERVICE.

## Timing
- Entry latency: the `insn_done` cycle with a request → next cycle TAKE → the following cycle PC = vector.
- Exit: the PC equals `epc` one cycle after the reti cycle.
- A pending request is evaluated at the first `insn_done` in IDLE after a reti. This guarantees at least one instruction of progress.
- Reset values: state IDLE, `pend=0`, `ie=0`, `epc=0`, `flush=0`, `irq_ack=0`, `in_service=0`, mask all ones.
  - `br_sel`/`imr_sel`/`rs` follow the `core_*` inputs.
  - The edge-detect history register resets to 0, so a line held high through reset latches on the first cycle after release.
- `rst` asserted mid-TAKE or mid-SERVICE returns to IDLE immediately, with no redirect.

## Configuration
- `INTR_MASK_EN` defined:
  - Adds `mask_we`/`mask_wdata`, plus an N_IRQ-bit mask register reset to all ones.
  - A write takes effect on the next cycle.
  - Masked lines stay pending and are taken once unmasked.
- `INTR_MASK_EN` undefined: the ports are absent and the mask is constant all ones.

## Structure
- `def.v` additions:
  - `INTR_ST_W` (2).
  - `INTR_ST_IDLE`, `INTR_ST_TAKE`, `INTR_ST_SERVICE`.
  - `INTR_N_IRQ_MAX` (8).
- One sub-module `intr_prio_enc`: combinational; outputs N_IRQ-bit req → valid + index. Index 0 has highest priority.

## Test plan
- `ie=1`, PC advancing, `irq[2]` edge, `insn_done` with `pc=0x0040` → TAKE: `rs=0x0014`, `flush=1`, `irq_ack=4'b0100`, `epc=0x0040`; next cycle PC=0x0014.
- `irq[1]` and `irq[3]` edges in the same cycle → index 1 taken (vector 0x0012); `pend[3]` remains; taken after reti plus one `insn_done`.
- SERVICE, `reti & insn_done` with `epc=0x0040` → `br_sel=1`, `imr_sel=1`, `rs=0x0040`; `ie=1`; state IDLE.
- `ie=0`, `irq[0]` edge → no TAKE, `pend[0]=1`; `ie_set` → taken at the next `insn_done`.
- Same-cycle `ie_set & ie_clr` → `ie=0`. Reset asserted in SERVICE → IDLE, `epc=0`, outputs pass through the `core_*` inputs.
- `INTR_MASK_EN`: write mask `4'b1110`, `irq[0]` edge → not taken; write `4'b1111` → vector 0x0010 taken.
